// File: rtl/mdu_hilo.sv
// Multiply/divide unit owning the HI/LO registers: fixed-latency multiply,
// restoring radix-2 divide with a sign-fixup cycle, plus direct MTHI/MTLO writes.
//
// state  | meaning
// S_IDLE | no operation in flight, accepts start_i
// S_MUL  | product already formed, counting down the multiply latency
// S_DIV  | one restoring-divide quotient bit per cycle, 32 cycles
// S_FIX  | sign fixup / divide-by-zero substitution, commits result
module mdu_hilo #(
    parameter int MUL_CYCLES = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        mthi_i,
    input  logic        mtlo_i,
    input  logic [31:0] wd_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int CW = ($clog2(MUL_CYCLES) > 5) ? $clog2(MUL_CYCLES) : 5;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     rem_q, rem_d, quo_q, quo_d;
    logic [31:0]     dvs_q, dvs_d, a_q, a_d;
    logic            negq_q, negq_d, negr_q, negr_d, dvz_q, dvz_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic            done_q, done_d;

    logic [63:0]     ext_a, ext_b, product;
    logic [31:0]     mag_a, mag_b;
    logic            is_sdiv;
    logic [32:0]     shifted;
    logic            sub_ok;
    logic            commit;
    logic [31:0]     res_hi, res_lo;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            a_q     <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dvz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            a_q     <= a_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dvz_q   <= dvz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        a_d     = a_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dvz_d   = dvz_q;
        commit  = 1'b0;
        res_hi  = rem_q;
        res_lo  = quo_q;

        // op_i[0] selects unsigned; sign-extending to 64 bits makes one multiplier serve both
        is_sdiv = ~op_i[0];
        ext_a   = op_i[0] ? {32'd0, a_i} : {{32{a_i[31]}}, a_i};
        ext_b   = op_i[0] ? {32'd0, b_i} : {{32{b_i[31]}}, b_i};
        product = ext_a * ext_b;
        mag_a   = (is_sdiv && a_i[31]) ? -a_i : a_i;
        mag_b   = (is_sdiv && b_i[31]) ? -b_i : b_i;

        shifted = {rem_q, quo_q[31]};
        sub_ok  = shifted >= {1'b0, dvs_q};

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (op_i[1]) begin
                        state_d = S_DIV;
                        cnt_d   = CW'(31);
                        rem_d   = '0;
                        quo_d   = mag_a;
                        dvs_d   = mag_b;
                        a_d     = a_i;
                        dvz_d   = (b_i == 32'd0);
                        negq_d  = is_sdiv & (a_i[31] ^ b_i[31]);
                        negr_d  = is_sdiv & a_i[31];
                    end else begin
                        state_d        = S_MUL;
                        cnt_d          = CW'(MUL_CYCLES - 1);
                        {rem_d, quo_d} = product;
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DIV: begin
                // remainder stays below the divisor, so the low 32 bits are exact
                rem_d = sub_ok ? (shifted[31:0] - dvs_q) : shifted[31:0];
                quo_d = {quo_q[30:0], sub_ok};
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FIX: begin
                commit  = 1'b1;
                state_d = S_IDLE;
                if (dvz_q) begin
                    res_hi = a_q;
                    res_lo = 32'hFFFF_FFFF;
                end else begin
                    res_hi = negr_q ? -rem_q : rem_q;
                    res_lo = negq_q ? -quo_q : quo_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        done_d = commit;
        hi_d   = mthi_i ? wd_i : (commit ? res_hi : hi_q);
        lo_d   = mtlo_i ? wd_i : (commit ? res_lo : lo_q);
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule
